// File: rtl/mem_stage_if.sv
// EX/MEM input bundle and MEM/WB output bundle of the memory stage.
// master drives the instruction side, slave is the stage itself.
interface mem_stage_if #(
  parameter int DATA_W = 32
);
  logic              in_valid;
  logic              mem_read;
  logic              mem_write;
  logic              reg_write;
  logic              mem_to_reg;
  logic [4:0]        rd;
  logic [DATA_W-1:0] alu_result;
  logic [DATA_W-1:0] store_data;
  logic              stall;
  logic              out_valid;
  logic              out_reg_write;
  logic [4:0]        out_rd;
  logic [DATA_W-1:0] out_wb_data;
  logic              out_err;

  modport master (
    output in_valid, mem_read, mem_write,
    output reg_write, mem_to_reg, rd,
    output alu_result, store_data,
    input  stall, out_valid, out_reg_write,
    input  out_rd, out_wb_data, out_err
  );

  modport slave (
    input  in_valid, mem_read, mem_write,
    input  reg_write, mem_to_reg, rd,
    input  alu_result, store_data,
    output stall, out_valid, out_reg_write,
    output out_rd, out_wb_data, out_err
  );
endinterface

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: fixed-latency load/store against a
// word-addressed data memory, stalling upstream while busy.
module mem_stage #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 256,
  parameter int LAT    = 2
) (
  input logic       clk,
  input logic       reset,
  mem_stage_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(LAT) + 1;

  typedef enum logic {IDLE, BUSY} state_e;

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              wr_q, wr_d;
  logic              rw_q, rw_d;
  logic              m2r_q, m2r_d;
  logic [4:0]        rd_q, rd_d;
  logic [DATA_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] sd_q, sd_d;

  logic              out_valid_q, out_valid_d;
  logic              out_rw_q, out_rw_d;
  logic              out_err_q, out_err_d;
  logic [4:0]        out_rd_q, out_rd_d;
  logic [DATA_W-1:0] out_wb_q, out_wb_d;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata;
  logic              mem_we;
  logic              stall;
  logic              mem_op;
  logic              illegal;

  assign mem_op  = bus.in_valid & (bus.mem_read | bus.mem_write);
  assign illegal = mem_op &
                   ((bus.alu_result[1:0] != 2'b00) |
                    (bus.mem_read & bus.mem_write));
  assign rdata   = mem_q[addr_q[AW+1:2]];

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    wr_d        = wr_q;
    rw_d        = rw_q;
    m2r_d       = m2r_q;
    rd_d        = rd_q;
    addr_d      = addr_q;
    sd_d        = sd_q;
    out_valid_d = out_valid_q;
    out_rw_d    = out_rw_q;
    out_err_d   = out_err_q;
    out_rd_d    = out_rd_q;
    out_wb_d    = out_wb_q;
    stall       = 1'b0;
    mem_we      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (mem_op && !illegal) begin
          stall       = 1'b1;
          wr_d        = bus.mem_write;
          rw_d        = bus.reg_write;
          m2r_d       = bus.mem_to_reg;
          rd_d        = bus.rd;
          addr_d      = bus.alu_result;
          sd_d        = bus.store_data;
          cnt_d       = CW'(LAT - 1);
          state_d     = BUSY;
          out_valid_d = 1'b0;
          out_rw_d    = 1'b0;
          out_err_d   = 1'b0;
        end else begin
          out_valid_d = bus.in_valid;
          out_rd_d    = bus.rd;
          out_wb_d    = bus.alu_result;
          out_err_d   = illegal;
          out_rw_d    = bus.reg_write & bus.in_valid & ~illegal;
        end
      end
      BUSY: begin
        if (cnt_q != '0) begin
          stall       = 1'b1;
          cnt_d       = cnt_q - 1'b1;
          out_valid_d = 1'b0;
          out_rw_d    = 1'b0;
          out_err_d   = 1'b0;
        end else begin
          mem_we      = wr_q;
          out_valid_d = 1'b1;
          out_rd_d    = rd_q;
          out_rw_d    = rw_q;
          out_err_d   = 1'b0;
          out_wb_d    = (!wr_q && m2r_q) ? rdata : addr_q;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      wr_q        <= 1'b0;
      rw_q        <= 1'b0;
      m2r_q       <= 1'b0;
      rd_q        <= '0;
      addr_q      <= '0;
      sd_q        <= '0;
      out_valid_q <= 1'b0;
      out_rw_q    <= 1'b0;
      out_err_q   <= 1'b0;
      out_rd_q    <= '0;
      out_wb_q    <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      wr_q        <= wr_d;
      rw_q        <= rw_d;
      m2r_q       <= m2r_d;
      rd_q        <= rd_d;
      addr_q      <= addr_d;
      sd_q        <= sd_d;
      out_valid_q <= out_valid_d;
      out_rw_q    <= out_rw_d;
      out_err_q   <= out_err_d;
      out_rd_q    <= out_rd_d;
      out_wb_q    <= out_wb_d;
    end
  end

  // Contents survive reset; an aborted store never reaches the array.
  always_ff @(posedge clk) begin
    if (!reset && mem_we) begin
      mem_q[addr_q[AW+1:2]] <= sd_q;
    end
  end

  assign bus.stall         = stall;
  assign bus.out_valid     = out_valid_q;
  assign bus.out_reg_write = out_rw_q;
  assign bus.out_err       = out_err_q;
  assign bus.out_rd        = out_rd_q;
  assign bus.out_wb_data   = out_wb_q;
endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: directed scenarios plus random
// instructions checked against an array-based memory model.
module tb_mem_stage;
  localparam int DW  = 32;
  localparam int LAT = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mem_stage_if #(.DATA_W(DW)) bus ();

  mem_stage #(
    .DATA_W(DW),
    .DEPTH (256),
    .LAT   (LAT)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct {
    int unsigned cyc;
    logic [4:0]  rd;
    logic [31:0] wb;
    logic        rw;
    logic        err;
  } exp_t;

  exp_t        sbq[$];
  logic [31:0] mdl [256];
  int          errors = 0;
  int          checks = 0;
  int unsigned cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  // Monitor: every valid output must match the oldest expectation.
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.out_valid) begin
        if (sbq.size() == 0) begin
          chk("unexpected_valid", 32'(bus.out_valid), 0);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          chk("out_cycle", cyc, e.cyc);
          chk("out_rd", 32'(bus.out_rd), 32'(e.rd));
          chk("out_wb_data", bus.out_wb_data, e.wb);
          chk("out_reg_write", 32'(bus.out_reg_write), 32'(e.rw));
          chk("out_err", 32'(bus.out_err), 32'(e.err));
        end
      end else begin
        chk("bubble_reg_write", 32'(bus.out_reg_write), 0);
      end
    end
  end

  task automatic drive(input logic v, r, w, rw, m2r,
                       input logic [4:0] rd,
                       input logic [31:0] a, sd);
    bus.in_valid   = v;
    bus.mem_read   = r;
    bus.mem_write  = w;
    bus.reg_write  = rw;
    bus.mem_to_reg = m2r;
    bus.rd         = rd;
    bus.alu_result = a;
    bus.store_data = sd;
  endtask

  // Present one instruction, hold it while stalled, predict its result.
  task automatic issue(input logic v, r, w, rw, m2r,
                       input logic [4:0] rd,
                       input logic [31:0] a, sd);
    logic mop, ill;
    int   st;
    int   idx;
    exp_t e;
    st  = 0;
    mop = v & (r | w);
    ill = mop & ((a % 4 != 0) | (r & w));
    idx = int'((a / 4) % 256);
    drive(v, r, w, rw, m2r, rd, a, sd);
    for (int i = 0; i < LAT + 4; i++) begin
      @(negedge clk);
      if (!bus.stall) break;
      st++;
    end
    chk("stall_cycles", st, (mop && !ill) ? LAT : 0);
    if (v) begin
      e.cyc = cyc + 1;
      e.rd  = rd;
      if (mop && !ill) begin
        e.rw  = rw;
        e.err = 1'b0;
        e.wb  = (r && m2r) ? mdl[idx] : a;
        if (w) mdl[idx] = sd;
      end else begin
        e.rw  = rw & ~ill;
        e.err = ill;
        e.wb  = a;
      end
      sbq.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic abort_store(input logic [31:0] a, sd);
    drive(1, 0, 1, 0, 0, 5'd0, a, sd);
    @(negedge clk);
    chk("abort_stall_pre", 32'(bus.stall), 1);
    @(posedge clk);
    #1;
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 5'd0, 0, 0);
    @(posedge clk);
    @(negedge clk);
    chk("abort_valid", 32'(bus.out_valid), 0);
    chk("abort_rd", 32'(bus.out_rd), 0);
    chk("abort_wb", bus.out_wb_data, 0);
    chk("abort_err", 32'(bus.out_err), 0);
    chk("abort_stall", 32'(bus.stall), 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    logic [31:0] a;
    int          rs;
    drive(0, 0, 0, 0, 0, 5'd0, 0, 0);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", 32'(bus.out_valid), 0);
    chk("rst_reg_write", 32'(bus.out_reg_write), 0);
    chk("rst_err", 32'(bus.out_err), 0);
    chk("rst_rd", 32'(bus.out_rd), 0);
    chk("rst_wb", bus.out_wb_data, 0);
    chk("rst_stall", 32'(bus.stall), 0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    issue(1, 0, 0, 1, 0, 5'd5, 32'h1234, 0);
    issue(1, 0, 1, 0, 0, 5'd0, 32'h40, 32'hDEADBEEF);
    issue(1, 1, 0, 1, 1, 5'd7, 32'h40, 0);
    issue(1, 0, 1, 0, 0, 5'd0, 32'h400, 32'hA5A5A5A5);
    issue(1, 1, 0, 1, 1, 5'd3, 32'h401, 0);
    issue(1, 1, 0, 1, 1, 5'd4, 32'h400, 0);
    issue(1, 0, 1, 0, 0, 5'd0, 32'h400, 32'h55);
    issue(1, 1, 0, 1, 1, 5'd6, 32'h000, 0);
    issue(1, 0, 1, 0, 0, 5'd0, 32'h10, 32'h11);
    abort_store(32'h10, 32'h99);
    issue(1, 1, 0, 1, 1, 5'd8, 32'h10, 0);
    issue(1, 0, 0, 1, 0, 5'd9, 32'hCAFE, 0);
    issue(1, 1, 0, 1, 1, 5'd10, 32'h40, 0);
    issue(1, 0, 0, 1, 0, 5'd11, 32'hBEEF, 0);
    issue(0, 0, 0, 1, 0, 5'd12, 32'h77, 0);
    issue(1, 1, 1, 1, 1, 5'd13, 32'h20, 0);

    for (int i = 0; i < 16; i++) begin
      issue(1, 0, 1, 0, 0, 5'd0, 32'(i * 4), $urandom);
    end

    for (int i = 0; i < 300; i++) begin
      a = $urandom & 32'hFFFF_FC3C;
      if ($urandom_range(0, 7) == 0) a = a | 32'($urandom_range(0, 3));
      rs = $urandom_range(0, 9);
      issue($urandom_range(0, 9) != 0,
            rs inside {[3:5], 9},
            rs inside {[6:9]},
            1'($urandom),
            1'($urandom),
            5'($urandom),
            a,
            $urandom);
    end

    drive(0, 0, 0, 0, 0, 5'd0, 0, 0);
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("queue_drained", sbq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
